// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {StIdle, StXfer} arb_state_t;

  // Index width for NREQ requesters; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width: must be able to hold MAX_BURST.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping mod NREQ.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IdW-1:0]  i_last_id,
  output logic [IdW-1:0]  o_winner,
  output logic            o_valid
);

  // Scan farthest-to-nearest so the nearest set request after last_id overwrites the rest.
  always_comb begin
    logic [IdW-1:0] w_pos;
    o_winner = '0;
    o_valid  = 1'b0;
    w_pos    = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      w_pos = IdW'((int'(i_last_id) + k) % int'(NREQ));
      if (i_req[w_pos]) begin
        o_winner = w_pos;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one TX fifo write port among NREQ requesters.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*WIDTH-1:0]      i_req_data,
  input  logic [NREQ-1:0]            i_req_last,
  output logic [NREQ-1:0]            o_gnt,
  output logic                       o_fifo_wr,
  output logic [WIDTH-1:0]           o_fifo_wr_data,
  input  logic                       i_fifo_full,
  output logic                       o_busy,
  output logic [idx_width(NREQ)-1:0] o_grant_id
);

  localparam int unsigned IdW  = idx_width(NREQ);
  localparam int unsigned CntW = cnt_width(MAX_BURST);
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

  arb_state_t      r_state, w_state_nxt;
  logic [IdW-1:0]  r_last_id, w_last_id_nxt;
  logic [IdW-1:0]  r_grant_id, w_grant_id_nxt;
  logic [CntW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [IdW-1:0]  w_winner;
  logic            w_winner_vld;
  logic            w_accept;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_rr_pick (
    .i_req     (i_req),
    .i_last_id (r_last_id),
    .o_winner  (w_winner),
    .o_valid   (w_winner_vld)
  );

  // A beat moves only while a grant is held, the requester is present and the fifo has room.
  assign w_accept = !rst && (r_state == StXfer) && i_req[r_grant_id] && !i_fifo_full;

  // State registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_last_id  <= IdW'(NREQ - 1);
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_id  <= w_last_id_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next-state: arbitrate in idle, count beats and detect burst end in xfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_id_nxt  = r_last_id;
    w_grant_id_nxt = r_grant_id;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_winner_vld) begin
          w_state_nxt    = StXfer;
          w_grant_id_nxt = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      StXfer: begin
        if (!i_req[r_grant_id]) begin
          // Requester abandoned the burst.
          w_state_nxt   = StIdle;
          w_last_id_nxt = r_grant_id;
        end else if (w_accept) begin
          if (i_req_last[r_grant_id] || (r_beat_cnt == LastBeat)) begin
            w_state_nxt   = StIdle;
            w_last_id_nxt = r_grant_id;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output mux: data forced to zero whenever no write happens.
  always_comb begin
    o_gnt          = '0;
    o_fifo_wr      = w_accept;
    o_fifo_wr_data = '0;
    if (w_accept) begin
      o_gnt[r_grant_id] = 1'b1;
      o_fifo_wr_data    = i_req_data[r_grant_id*WIDTH +: WIDTH];
    end
  end

  assign o_busy     = !rst && (r_state == StXfer);
  assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, checked each cycle.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_req_data;
  logic [NREQ-1:0]       i_req_last;
  logic [NREQ-1:0]       o_gnt;
  logic                  o_fifo_wr;
  logic [WIDTH-1:0]      o_fifo_wr_data;
  logic                  i_fifo_full;
  logic                  o_busy;
  logic [1:0]            o_grant_id;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_req_data     (i_req_data),
    .i_req_last     (i_req_last),
    .o_gnt          (o_gnt),
    .o_fifo_wr      (o_fifo_wr),
    .o_fifo_wr_data (o_fifo_wr_data),
    .i_fifo_full    (i_fifo_full),
    .o_busy         (o_busy),
    .o_grant_id     (o_grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester sources: each emits beats {id, seq}; len=0 means never flags last.
  bit src_on[NREQ];
  int src_seq[NREQ];
  int src_len[NREQ];
  int src_cnt[NREQ];
  int src_bursts[NREQ];

  // Reference arbiter model: grant held flag, granted id, beats done, last winner.
  bit m_busy;
  int m_id;
  int m_beats;
  int m_last;

  bit g_acc;
  int g_id;
  int n_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit src_last(input int i);
    return (src_len[i] != 0) && (src_cnt[i] == src_len[i] - 1);
  endfunction

  function automatic logic [7:0] src_beat(input int i);
    return {2'(i), 6'(src_seq[i])};
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      i_req[i]                     = src_on[i];
      i_req_last[i]                = src_last(i);
      i_req_data[i*WIDTH +: WIDTH] = src_beat(i);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_id    = 0;
    m_beats = 0;
    m_last  = NREQ - 1;
  endtask

  // One clock: check outputs, advance model across the edge, then advance sources.
  task automatic cycle();
    bit acc;
    bit rq;
    bit lst;
    logic [NREQ-1:0] req_s;
    #1;
    req_s = i_req;
    rq    = m_busy && src_on[m_id];
    lst   = m_busy && src_last(m_id);
    acc   = !rst && rq && !i_fifo_full;
    check("gnt", 32'(o_gnt), acc ? (32'd1 << m_id) : 32'd0);
    check("fifo_wr", 32'(o_fifo_wr), 32'(acc));
    check("fifo_wr_data", 32'(o_fifo_wr_data), acc ? 32'(src_beat(m_id)) : 32'd0);
    check("busy", 32'(o_busy), 32'(!rst && m_busy));
    check("grant_id", 32'(o_grant_id), 32'(m_id));
    g_acc = acc;
    g_id  = m_id;
    if (o_fifo_wr === 1'b1) n_wr++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (req_s != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req_s[(m_last + k) % NREQ]) begin
            m_id = (m_last + k) % NREQ;
            break;
          end
        end
        m_beats = 0;
        m_busy  = 1'b1;
      end
    end else if (!rq) begin
      m_busy = 1'b0;
      m_last = m_id;
    end else if (acc) begin
      m_beats++;
      if (lst || m_beats == MAX_BURST) begin
        m_busy = 1'b0;
        m_last = m_id;
      end
    end
    #1;
    if (acc) begin
      src_seq[g_id]++;
      if (src_last(g_id)) begin
        src_cnt[g_id] = 0;
        src_bursts[g_id]--;
        if (src_bursts[g_id] <= 0) src_on[g_id] = 1'b0;
      end else begin
        src_cnt[g_id]++;
      end
    end
    drive();
  endtask

  task automatic src_start(input int i, input int len, input int bursts);
    src_on[i]     = 1'b1;
    src_len[i]    = len;
    src_cnt[i]    = 0;
    src_bursts[i] = bursts;
    drive();
  endtask

  task automatic src_stop(input int i);
    src_on[i]  = 1'b0;
    src_cnt[i] = 0;
    drive();
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < NREQ; i++) begin
      src_on[i]  = 1'b0;
      src_seq[i] = 0;
      src_len[i] = 0;
      src_cnt[i] = 0;
      src_bursts[i] = 0;
    end
    model_reset();
    rst = 1'b1;
    i_fifo_full = 1'b0;
    drive();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Single requester, 3-beat burst.
    n_wr = 0;
    src_start(0, 3, 1);
    repeat (7) cycle();
    check("t1_writes", 32'(n_wr), 32'd3);
    check("t1_idle", 32'(o_busy), 32'd0);

    // All requesters continuous, never last: forced 4-beat bursts rotating.
    for (int i = 0; i < NREQ; i++) src_start(i, 0, 1);
    repeat (26) cycle();
    for (int i = 0; i < NREQ; i++) src_stop(i);
    repeat (3) cycle();

    // Fifo full for 3 cycles mid-burst.
    src_start(0, 0, 1);
    repeat (3) cycle();
    i_fifo_full = 1'b1;
    repeat (3) cycle();
    i_fifo_full = 1'b0;
    repeat (6) cycle();
    src_stop(0);
    repeat (2) cycle();

    // Requester 2 abandons after one beat; requester 3 then pending.
    src_start(2, 0, 1);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cycle();
      hit = g_acc && (g_id == 2);
    end
    check("t4_beat_seen", 32'(hit), 32'd1);
    src_stop(2);
    src_start(3, 2, 1);
    repeat (6) cycle();
    check("t4_last_id", 32'(m_last), 32'd3);

    // Reset mid-burst at beat 2.
    src_start(1, 0, 1);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cycle();
      hit = m_busy && (m_beats == 2);
    end
    check("t5_beat2", 32'(hit), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    src_start(0, 2, 1);
    cycle();
    check("t5_first_winner", 32'(o_grant_id), 32'd0);
    repeat (6) cycle();
    for (int i = 0; i < NREQ; i++) src_stop(i);
    cycle();

    // Random traffic, including abandons and fifo back-pressure.
    repeat (2000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!src_on[i]) begin
          if ($urandom_range(3) == 0) src_start(i, int'($urandom_range(6)), 1);
        end else if ($urandom_range(40) == 0) begin
          src_stop(i);
        end
      end
      i_fifo_full = ($urandom_range(2) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
